// File: rtl/secded16_encoder_if.sv
// Valid/ready bundle between a word source, the SEC/DED encoder and a codeword sink.
// The master is the environment that drives words in and drains codewords out.
interface secded16_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [21:0] in_inj;
    logic        out_valid;
    logic        out_ready;
    logic [21:0] out_code;

    modport master (
        output in_valid, in_data, in_inj, out_ready,
        input  in_ready, out_valid, out_code
    );

    modport slave (
        input  in_valid, in_data, in_inj, out_ready,
        output in_ready, out_valid, out_code
    );
endinterface

// File: rtl/secded16_encoder.sv
// Hamming(22,16) SEC/DED encoder with optional error-injection mask, buffered in a DEPTH-entry FIFO.
// One-cycle latency into an empty FIFO; in_ready is registered (occupancy < DEPTH), independent of out_ready.
module secded16_encoder #(
    parameter int DEPTH   = 2,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    secded16_encoder_if.slave  bus,
    output logic [COUNT_W-1:0] word_cnt,
    output logic [COUNT_W-1:0] inj_cnt
);
    localparam int         PTR_W   = (DEPTH > 2) ? 2 : 1;
    localparam logic [2:0] DEPTH_L = 3'(DEPTH);

    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [2:0]         r_occ;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [21:0]        r_mem [DEPTH];
    logic [COUNT_W-1:0] r_word_cnt;
    logic [COUNT_W-1:0] r_inj_cnt;

    logic               w_push;
    logic               w_pop;
    logic [2:0]         w_occ_nxt;
    logic [21:0]        w_code;

    // Data bits fill the non-power-of-two positions in ascending order; each check bit
    // at 2^k is the even parity of the data positions whose index has bit k set.
    function automatic logic [21:0] encode(input logic [15:0] d);
        logic [21:0] c;
        logic [4:0]  p;
        logic [4:0]  pk;
        logic [3:0]  j;
        logic        par;
        c = '0;
        j = '0;
        for (int i = 1; i < 22; i++) begin
            p = 5'(i);
            if ((p & (p - 5'd1)) != 5'd0) begin
                c[p] = d[j];
                j    = j + 4'd1;
            end
        end
        for (int k = 0; k < 5; k++) begin
            pk  = 5'd1 << k;
            par = 1'b0;
            for (int i = 3; i < 22; i++) begin
                p = 5'(i);
                if (((p & (p - 5'd1)) != 5'd0) && ((p & pk) != 5'd0))
                    par = par ^ c[p];
            end
            c[pk] = par;
        end
        c[0] = ^c[21:1];
        return c;
    endfunction

    assign w_push = bus.in_valid & r_in_ready;
    assign w_pop  = r_out_valid & bus.out_ready;
    assign w_code = encode(bus.in_data) ^ bus.in_inj;

    always_comb begin
        w_occ_nxt = r_occ;
        if (w_push && !w_pop)
            w_occ_nxt = r_occ + 3'd1;
        else if (!w_push && w_pop)
            w_occ_nxt = r_occ - 3'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_occ       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_word_cnt  <= '0;
            r_inj_cnt   <= '0;
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= '0;
        end else begin
            r_occ       <= w_occ_nxt;
            r_in_ready  <= (w_occ_nxt < DEPTH_L);
            r_out_valid <= (w_occ_nxt != 3'd0);
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_code;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
                if (r_word_cnt != '1)
                    r_word_cnt <= r_word_cnt + 1'b1;
                if ((bus.in_inj != 22'd0) && (r_inj_cnt != '1))
                    r_inj_cnt <= r_inj_cnt + 1'b1;
            end
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_code  = r_mem[r_rd_ptr];
    assign word_cnt      = r_word_cnt;
    assign inj_cnt       = r_inj_cnt;
endmodule

// File: tb/tb_secded16_encoder.sv
// Directed bench for secded16_encoder: encode table, backpressure, streaming, reset,
// plus a DEPTH=4 / COUNT_W=4 instance for deeper ordering and counter saturation.
module tb_secded16_encoder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    secded16_encoder_if bus ();
    secded16_encoder_if bus2 ();
    logic [15:0] word_cnt;
    logic [15:0] inj_cnt;
    logic [3:0]  word_cnt2;
    logic [3:0]  inj_cnt2;

    secded16_encoder #(.DEPTH(2), .COUNT_W(16)) dut (
        .clk(clk), .rst(rst), .bus(bus), .word_cnt(word_cnt), .inj_cnt(inj_cnt)
    );
    secded16_encoder #(.DEPTH(4), .COUNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .bus(bus2), .word_cnt(word_cnt2), .inj_cnt(inj_cnt2)
    );

    typedef struct {
        logic [15:0] d;
        logic [21:0] inj;
        logic [21:0] exp;
    } vec_t;

    localparam int NV = 9;
    vec_t tab [NV];
    int total = 0;
    int bad   = 0;
    int exp_words = 0;
    int exp_injs  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tab[0] = '{16'h0001, 22'h000000, 22'h00000F};
        tab[1] = '{16'h0000, 22'h000000, 22'h000000};
        tab[2] = '{16'hFFFF, 22'h000000, 22'h3FFFFC};
        tab[3] = '{16'hFFFF, 22'h000100, 22'h3FFEFC};
        tab[4] = '{16'h0002, 22'h000000, 22'h000033};
        tab[5] = '{16'h8000, 22'h000000, 22'h210012};
        tab[6] = '{16'h0010, 22'h000000, 22'h000303};
        tab[7] = '{16'h0800, 22'h000000, 22'h030003};
        tab[8] = '{16'h0000, 22'h3FFFFF, 22'h3FFFFF};

        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.in_inj     = '0;
        bus.out_ready  = 1'b0;
        bus2.in_valid  = 1'b0;
        bus2.in_data   = '0;
        bus2.in_inj    = '0;
        bus2.out_ready = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();

        // Reset state
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_code", 32'(bus.out_code), 32'd0);
        chk("rst_word_cnt", 32'(word_cnt), 32'd0);
        chk("rst_inj_cnt", 32'(inj_cnt), 32'd0);

        // Table: one word at a time through an empty FIFO
        bus.out_ready = 1'b1;
        for (int i = 0; i < NV; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = tab[i].d;
            bus.in_inj   = tab[i].inj;
            step();
            bus.in_valid = 1'b0;
            exp_words++;
            if (tab[i].inj != 22'd0) exp_injs++;
            chk("tab_out_valid", 32'(bus.out_valid), 32'd1);
            chk($sformatf("tab_code[%0d]", i), 32'(bus.out_code), 32'(tab[i].exp));
            chk("tab_word_cnt", 32'(word_cnt), 32'(exp_words));
            chk("tab_inj_cnt", 32'(inj_cnt), 32'(exp_injs));
            step();
            chk("tab_drained", 32'(bus.out_valid), 32'd0);
        end

        // Backpressure: fill DEPTH=2, third word held until space frees
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_inj    = '0;
        bus.in_data   = 16'h0001;
        step();
        chk("bp_ready_after1", 32'(bus.in_ready), 32'd1);
        bus.in_data = 16'h0000;
        step();
        chk("bp_ready_after2", 32'(bus.in_ready), 32'd0);
        bus.in_data = 16'hFFFF;
        step();
        chk("bp_held", 32'(bus.in_ready), 32'd0);
        chk("bp_cnt_held", 32'(word_cnt), 32'(exp_words + 2));
        bus.out_ready = 1'b1;
        chk("bp_head0", 32'(bus.out_code), 32'h00000F);
        step();
        chk("bp_no_accept_when_full", 32'(word_cnt), 32'(exp_words + 2));
        chk("bp_head1", 32'(bus.out_code), 32'h000000);
        step();
        bus.in_valid = 1'b0;
        chk("bp_head2", 32'(bus.out_code), 32'h3FFFFC);
        step();
        chk("bp_empty", 32'(bus.out_valid), 32'd0);
        exp_words += 3;
        chk("bp_word_cnt", 32'(word_cnt), 32'(exp_words));

        // Streaming at occupancy 1: accept and drain each cycle
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = tab[0].d;
        bus.in_inj    = tab[0].inj;
        step();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.in_data = tab[(i + 1) % NV].d;
            bus.in_inj  = tab[(i + 1) % NV].inj;
            chk($sformatf("stream_code[%0d]", i), 32'(bus.out_code), 32'(tab[i % NV].exp));
            chk("stream_ready", 32'(bus.in_ready), 32'd1);
            chk("stream_valid", 32'(bus.out_valid), 32'd1);
            step();
        end
        bus.in_valid = 1'b0;
        chk("stream_last", 32'(bus.out_code), 32'(tab[10 % NV].exp));
        step();
        chk("stream_empty", 32'(bus.out_valid), 32'd0);
        for (int i = 0; i <= 10; i++) begin
            exp_words++;
            if (tab[i % NV].inj != 22'd0) exp_injs++;
        end
        chk("stream_word_cnt", 32'(word_cnt), 32'(exp_words));
        chk("stream_inj_cnt", 32'(inj_cnt), 32'(exp_injs));

        // Reset mid-stream with two words buffered; accept in reset cycle ignored
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 16'h0001;
        step();
        step();
        chk("pre_rst_full", 32'(bus.in_ready), 32'd0);
        rst = 1'b1;
        bus.out_ready = 1'b1;
        step();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("mid_rst_word_cnt", 32'(word_cnt), 32'd0);
        chk("mid_rst_inj_cnt", 32'(inj_cnt), 32'd0);
        step();
        chk("mid_rst_stays_empty", 32'(bus.out_valid), 32'd0);

        // DEPTH=4 instance: fill, check order, then saturate 4-bit counters
        bus2.out_ready = 1'b0;
        bus2.in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus2.in_data = tab[i + 4].d;
            bus2.in_inj  = tab[i + 4].inj;
            step();
        end
        bus2.in_valid = 1'b0;
        chk("d4_full", 32'(bus2.in_ready), 32'd0);
        bus2.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("d4_code[%0d]", i), 32'(bus2.out_code), 32'(tab[i + 4].exp));
            step();
        end
        chk("d4_empty", 32'(bus2.out_valid), 32'd0);
        chk("d4_word_cnt", 32'(word_cnt2), 32'd4);
        bus2.in_valid = 1'b1;
        bus2.in_data  = 16'h1234;
        bus2.in_inj   = 22'h000001;
        for (int i = 0; i < 20; i++)
            step();
        bus2.in_valid = 1'b0;
        chk("sat_word_cnt", 32'(word_cnt2), 32'd15);
        chk("sat_inj_cnt", 32'(inj_cnt2), 32'd15);
        step();
        step();
        chk("sat_word_hold", 32'(word_cnt2), 32'd15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
